// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the RV32I instruction-fetch stage and its neighbours
// (decode / immediate generator): the fetch FSM state type, the PC step, the
// canonical NOP encoding and the base-ISA major opcodes.
// No ports; imported with `import fetch_pkg::*;`.
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    localparam int unsigned PC_STEP  = 4;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // RV32I major opcodes (inst[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // True for instructions that may later cause a redirect of this stage.
    function automatic logic is_ctrl_flow(input logic [31:0] inst);
        return (inst[6:0] == OPC_JAL) || (inst[6:0] == OPC_JALR) ||
               (inst[6:0] == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO buffering {instruction, pc} pairs between the
// instruction memory response and decode.
// Parameters: DEPTH (power of 2, >= 2), DW (payload width).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush_i         drop all entries (wins over push and pop)
//   push_i, data_i  write an entry (accepted when not full, or full with pop)
//   pop_i           remove the head entry (ignored when empty)
//   data_o          head entry (undefined content when empty)
//   count_o         number of stored entries
//   full_o, empty_o occupancy flags
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned DW    = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [DW-1:0]          data_i,
    input  logic                   pop_i,
    output logic [DW-1:0]          data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

    // A push into a full FIFO is fine when the head leaves in the same cycle;
    // the write slot is then the one being vacated.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Instruction-fetch stage of the RV32I core. Owns the PC, issues in-order
// requests to instruction memory, buffers returned words in fetch_fifo and
// presents {inst_o, pc_o} to decode over a valid/ready handshake. A redirect
// flushes the stage, discards responses still in flight and restarts fetch
// at the target.
// Parameters: WIDTH (data/address width), RESET_PC (first fetch address),
//             FIFO_DEPTH (buffer entries = max outstanding+buffered words).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   redirect_i, redirect_pc_i  load new PC and flush
//   imem_req_o, imem_addr_o    memory request / word-aligned address
//   imem_gnt_i                 request accepted this cycle
//   imem_rvalid_i, imem_rdata_i in-order response
//   inst_valid_o, inst_ready_i handshake to decode
//   inst_o, pc_o               instruction word and its address
// Build option MISALIGN_TRAP_EN: a redirect to a non-word-aligned target
// stops fetching and raises trap_o / trap_pc_o until the next aligned
// redirect. Without it the target's low two bits are forced to zero.
// ---------------------------------------------------------------------------
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned       WIDTH      = 32,
    parameter logic [WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [WIDTH-1:0] imem_rdata_i,
    output logic             inst_valid_o,
    input  logic             inst_ready_i,
    output logic [WIDTH-1:0] inst_o,
    output logic [WIDTH-1:0] pc_o
`ifdef MISALIGN_TRAP_EN
    ,
    output logic             trap_o,
    output logic [WIDTH-1:0] trap_pc_o
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]    out_q, out_d;
    logic [CW-1:0]    drop_q, drop_d;

    logic [2*WIDTH-1:0] fifo_rdata;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               fifo_push;
    logic               gnt_acc;
    logic [CW-1:0]      credit_used;
    logic [WIDTH-1:0]   redirect_target;
    logic               fetch_halt;

    assign fifo_pop  = !fifo_empty && inst_ready_i;
    assign gnt_acc   = imem_req_o && imem_gnt_i;
    assign fifo_push = imem_rvalid_i && (drop_q == '0);

    // Slots committed to words either buffered or still in flight. The head
    // leaving this cycle frees its slot, which keeps one request per cycle
    // flowing in steady state with only two entries.
    assign credit_used = out_q + fifo_count - CW'(fifo_pop);

`ifdef MISALIGN_TRAP_EN
    logic             trap_q;
    logic [WIDTH-1:0] trap_pc_q;
    logic             misaligned;

    assign misaligned      = (redirect_pc_i[1:0] != 2'b00);
    assign redirect_target = redirect_pc_i;
    assign fetch_halt      = trap_q;

    // Trap raised by a misaligned redirect; only an aligned one clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q    <= 1'b0;
            trap_pc_q <= '0;
        end else if (redirect_i) begin
            trap_q    <= misaligned;
            trap_pc_q <= misaligned ? redirect_pc_i : '0;
        end
    end

    assign trap_o    = trap_q;
    assign trap_pc_o = trap_pc_q;
`else
    assign redirect_target = redirect_pc_i & {{(WIDTH-2){1'b1}}, 2'b00};
    assign fetch_halt      = 1'b0;
`endif

    // FSM: one idle BOOT cycle, then RUN forever. Requests only in RUN, never
    // during a redirect cycle (the request is withdrawn), and only while a
    // buffer slot is guaranteed for the returning word.
    always_comb begin
        state_d    = state_q;
        imem_req_o = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                imem_req_o = (credit_used < CW'(FIFO_DEPTH)) && !redirect_i && !fetch_halt;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign imem_addr_o = pc_q;

    // PC, response-PC, outstanding and drop bookkeeping. On a redirect every
    // word still in flight after this cycle belongs to the old path, so the
    // drop count becomes the updated outstanding count.
    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        drop_d    = drop_q;
        out_d     = out_q + CW'(gnt_acc) - CW'(imem_rvalid_i);
        if (gnt_acc) begin
            pc_d = pc_q + WIDTH'(PC_STEP);
        end
        if (imem_rvalid_i) begin
            if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end else begin
                resp_pc_d = resp_pc_q + WIDTH'(PC_STEP);
            end
        end
        if (redirect_i) begin
            pc_d      = redirect_target;
            resp_pc_d = redirect_target;
            drop_d    = out_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (2 * WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_i),
        .push_i  (fifo_push && !fifo_full || fifo_push && fifo_pop),
        .data_i  ({imem_rdata_i, resp_pc_q}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Head is presented as zeros while the buffer is empty.
    assign inst_valid_o    = !fifo_empty;
    assign {inst_o, pc_o}  = fifo_empty ? '0 : fifo_rdata;

endmodule
